// File: rtl/player_renderer.sv
// player_renderer: draw-side consumer of the player position bus.
// Once per accepted frame tick it erases the sprite at the last drawn
// position, then draws it at the newly sampled position, one pixel per
// clock, into a 160x120, 3-bit colour VGA pixel port.
//
// Optional build macro: SKIP_UNCHANGED_EN
//   defined     - a frame whose position matches the last drawn position
//                 skips straight to DONE (oDone pulses, no pixels issued).
//   not defined - every accepted frame performs the full erase + draw.
module player_renderer #(
    parameter int         SPRITE_W      = 8,
    parameter int         SPRITE_H      = 12,
    parameter logic [2:0] PLAYER_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter int         SCREEN_W      = 160,
    parameter int         SCREEN_H      = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       gameStart,
    input  logic       frameEn,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oBusy,
    output logic       oDone
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] CX_LAST = 4'(SPRITE_W - 1);
    localparam logic [3:0] CY_LAST = 4'(SPRITE_H - 1);

    // Clip test on the unwrapped (widened) pixel coordinate.
    function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
        return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
    endfunction

    logic [1:0] state;
    logic [3:0] cx;
    logic [3:0] cy;
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic [7:0] prev_x;
    logic [6:0] prev_y;
    logic       drawn_valid;

    // Issue-stage signals: the pixel selected by (cx,cy) this cycle.
    logic       vld_p0;
    logic       last_pix_p0;
    logic [7:0] base_x_p0;
    logic [6:0] base_y_p0;
    logic [8:0] pix_x_p0;
    logic [7:0] pix_y_p0;
    logic [2:0] colour_p0;
    logic       start_frame;
    logic       skip_frame;

`ifdef SKIP_UNCHANGED_EN
    assign skip_frame = drawn_valid && (iX == prev_x) && (iY == prev_y);
`else
    assign skip_frame = 1'b0;
`endif

    assign start_frame = (state == S_IDLE) && frameEn && gameStart;

    // Issue stage: form the pixel coordinate and colour for the current counters.
    always_comb begin
        vld_p0      = (state == S_ERASE) || (state == S_DRAW);
        last_pix_p0 = (cx == CX_LAST) && (cy == CY_LAST);
        base_x_p0   = (state == S_ERASE) ? prev_x : new_x;
        base_y_p0   = (state == S_ERASE) ? prev_y : new_y;
        pix_x_p0    = {1'b0, base_x_p0} + {5'b0, cx};
        pix_y_p0    = {1'b0, base_y_p0} + {4'b0, cy};
        colour_p0   = (state == S_ERASE) ? BG_COLOUR : PLAYER_COLOUR;
    end

    // Frame sequencer: latch position, walk the sprite raster, commit on DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cx          <= 4'd0;
            cy          <= 4'd0;
            new_x       <= 8'd0;
            new_y       <= 7'd0;
            prev_x      <= 8'd0;
            prev_y      <= 7'd0;
            drawn_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        new_x <= iX;
                        new_y <= iY;
                        cx    <= 4'd0;
                        cy    <= 4'd0;
                        if (skip_frame)
                            state <= S_DONE;
                        else if (drawn_valid)
                            state <= S_ERASE;
                        else
                            state <= S_DRAW;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (last_pix_p0) begin
                        cx    <= 4'd0;
                        cy    <= 4'd0;
                        state <= (state == S_ERASE) ? S_DRAW : S_DONE;
                    end else if (cx == CX_LAST) begin
                        cx <= 4'd0;
                        cy <= cy + 4'd1;
                    end else begin
                        cx <= cx + 4'd1;
                    end
                end
                S_DONE: begin
                    prev_x      <= new_x;
                    prev_y      <= new_y;
                    drawn_valid <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- p0 -> p1: registered pixel port ----
    // Output register: present the issued pixel one clock later, clipped pixels unplotted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oX      <= 8'd0;
            oY      <= 7'd0;
            oColour <= 3'd0;
            oPlot   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            oX      <= vld_p0 ? pix_x_p0[7:0] : 8'd0;
            oY      <= vld_p0 ? pix_y_p0[6:0] : 7'd0;
            oColour <= vld_p0 ? colour_p0 : 3'd0;
            oPlot   <= vld_p0 && on_screen(pix_x_p0, pix_y_p0);
            oBusy   <= vld_p0;
            oDone   <= (state == S_DONE);
        end
    end

endmodule

// File: tb/tb_player_renderer.sv
// Testbench for player_renderer with a 4x4 sprite.
module tb_player_renderer;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int N  = SW * SH;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       gameStart = 1'b0;
    logic       frameEn = 1'b0;
    logic [7:0] iX = 8'd0;
    logic [6:0] iY = 7'd0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot;
    logic       oBusy;
    logic       oDone;

    always #5 clock = ~clock;

    player_renderer #(.SPRITE_W(SW), .SPRITE_H(SH)) dut (
        .clock(clock), .reset(reset), .gameStart(gameStart), .frameEn(frameEn),
        .iX(iX), .iY(iY), .oX(oX), .oY(oY), .oColour(oColour),
        .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the screen should currently hold.
    int m_prev_x = 0;
    int m_prev_y = 0;
    bit m_valid  = 1'b0;

    typedef struct {
        int x;
        int y;
        int col;
        bit plot;
    } pix_t;
    pix_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic add_pass(input int bx, input int by, input int col);
        pix_t p;
        for (int yy = 0; yy < SH; yy++)
            for (int xx = 0; xx < SW; xx++) begin
                p.x = bx + xx;
                p.y = by + yy;
                p.col = col;
                p.plot = (p.x < 160) && (p.y < 120);
                exp_q.push_back(p);
            end
    endtask

    task automatic build_expected(input int x, input int y, output int n_erase);
        bit skip;
        exp_q.delete();
        skip = 1'b0;
`ifdef SKIP_UNCHANGED_EN
        skip = m_valid && (x == m_prev_x) && (y == m_prev_y);
`endif
        n_erase = 0;
        if (!skip) begin
            if (m_valid) begin
                add_pass(m_prev_x, m_prev_y, 0);
                n_erase = N;
            end
            add_pass(x, y, 7);
        end
    endtask

    // One frame: pulse frameEn, check every presented cycle against the model.
    // pulse_at / drop_at / abort_at are pixel indices (-1 = unused).
    task automatic render(input int x, input int y, input int pulse_at,
                          input int drop_at, input int abort_draw_idx);
        int n_erase;
        int abort_at;
        build_expected(x, y, n_erase);
        abort_at = (abort_draw_idx >= 0) ? n_erase + abort_draw_idx : -1;
        @(negedge clock);
        iX = x[7:0];
        iY = y[6:0];
        frameEn = 1'b1;
        @(negedge clock);
        frameEn = 1'b0;
        chk("lead_busy", oBusy, 0);
        chk("lead_plot", oPlot, 0);
        chk("lead_done", oDone, 0);
        foreach (exp_q[i]) begin
            @(negedge clock);
            frameEn = 1'b0;
            iX = x[7:0];
            chk("pix_busy", oBusy, 1);
            chk("pix_plot", oPlot, exp_q[i].plot);
            chk("pix_colour", oColour, exp_q[i].col);
            chk("pix_done", oDone, 0);
            if (exp_q[i].plot) begin
                chk("pix_x", oX, exp_q[i].x);
                chk("pix_y", oY, exp_q[i].y);
            end
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_plot", oPlot, 0);
                chk("abort_busy", oBusy, 0);
                chk("abort_xy", {oX, oY, oColour, oDone}, 0);
                @(negedge clock);
                reset = 1'b0;
                m_valid = 1'b0;
                m_prev_x = 0;
                m_prev_y = 0;
                return;
            end
            if (i == pulse_at) begin
                frameEn = 1'b1;
                iX = 8'(x + 3);
            end
            if (i == drop_at) gameStart = 1'b0;
        end
        @(negedge clock);
        chk("done_pulse", oDone, 1);
        chk("done_busy", oBusy, 0);
        chk("done_plot", oPlot, 0);
        m_prev_x = x;
        m_prev_y = y;
        m_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("idle_done", oDone, 0);
            chk("idle_busy", oBusy, 0);
        end
        gameStart = 1'b1;
    endtask

    initial begin
        int rx;
        int ry;
        // Reset state
        @(negedge clock);
        chk("rst_outputs", {oX, oY, oColour, oPlot, oBusy, oDone}, 0);
        reset = 1'b0;

        // gameStart low: frame ticks ignored
        @(negedge clock);
        frameEn = 1'b1;
        @(negedge clock);
        frameEn = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("nogame_busy", oBusy, 0);
            chk("nogame_done", oDone, 0);
        end
        gameStart = 1'b1;

        // First frame: draw only
        render(10, 20, -1, -1, -1);
        // Move right: erase old, draw new
        render(13, 20, -1, -1, -1);
        // Bottom-right corner clipping
        render(158, 118, -1, -1, -1);
        // frameEn during draw ignored, gameStart falling mid-pass completes
        render(40, 50, N + 6, N + 2, -1);
        // Reset at the 5th draw pixel
        render(60, 30, -1, -1, 4);
        // Next frame draws without erase
        render(61, 31, -1, -1, -1);
        // Same position repeated
        render(61, 31, -1, -1, -1);

        // Randomised positions, with occasional repeats and edge placement
        for (int k = 0; k < 8; k++) begin
            if (k % 3 == 2) begin
                rx = m_prev_x;
                ry = m_prev_y;
            end else if (k % 3 == 1) begin
                rx = $urandom_range(150, 255);
                ry = $urandom_range(110, 127);
            end else begin
                rx = $urandom_range(0, 255);
                ry = $urandom_range(0, 127);
            end
            render(rx, ry, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
